// File: rtl/ifetch_queue.sv
// Prefetching instruction-fetch FIFO between RAM port 1 and the decoder; entries carry their fetch address.
// Optional head bypass of returning RAM data when the queue is empty: define IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int                 ADDR_W   = 11,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         ram_rd_en1,
  output logic [ADDR_W-1:0]            ram_addr1,
  input  logic [DATA_W-1:0]            ram_data1,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         deq,
  output logic [DATA_W-1:0]            instr,
  output logic [ADDR_W-1:0]            instr_pc,
  output logic                         instr_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  fetch_pc, inflight_pc;
  logic               inflight;
  logic               head_valid, byp, deq_eff, deq_fifo, wr_en;
  logic [CW:0]        occ;

  assign head_valid = (count != '0);

`ifdef IFQ_BYPASS_EN
  assign byp = (count == '0) && inflight && !redirect;
`else
  assign byp = 1'b0;
`endif

  assign instr_valid = head_valid || byp;
  assign deq_eff     = deq && instr_valid && !redirect;
  // A bypassed word that is consumed on arrival never touches the FIFO.
  assign deq_fifo    = deq_eff && head_valid;
  assign wr_en       = inflight && !redirect && !(byp && deq_eff);

  // Occupancy after this cycle counts the read already in flight, so the FIFO can never overflow.
  assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq_eff};
  assign ram_rd_en1 = rst_n && !redirect && (occ < (CW+1)'(DEPTH));
  assign ram_addr1  = fetch_pc;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (byp) begin
      instr    = ram_data1;
      instr_pc = inflight_pc;
    end else if (head_valid) begin
      instr    = mem_q[rd_ptr].data;
      instr_pc = mem_q[rd_ptr].pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= ram_rd_en1;
      if (ram_rd_en1) begin
        fetch_pc    <= fetch_pc + 1'b1;
        inflight_pc <= fetch_pc;
      end
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (deq_fifo) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(deq_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= '{pc: inflight_pc, data: ram_data1};
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: RAM model returns 0xE000_0000 + address one cycle after each read.
module tb_ifetch_queue;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_rd_en1;
  logic [AW-1:0] ram_addr1;
  logic [DW-1:0] ram_data1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          deq = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  logic          log_en = 1'b0;
  logic [AW-1:0] issued [$];

  ifetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_rd_en1(ram_rd_en1), .ram_addr1(ram_addr1), .ram_data1(ram_data1),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    ram_data1 <= ram_rd_en1 ? (32'hE000_0000 + {21'b0, ram_addr1}) : 32'hDEAD_BEEF;

  always @(posedge clk)
    if (log_en && ram_rd_en1) issued.push_back(ram_addr1);

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (ram_rd_en1 !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", ram_rd_en1); end
    n_cmp++; if (ram_addr1 !== 11'h000) begin n_bad++; $display("FAIL reset_addr: got %h want 000", ram_addr1); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 11'h000) begin n_bad++; $display("FAIL reset_instr_pc: got %h want 000", instr_pc); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
  endtask

  task automatic test_fill;
    issued.delete();
    log_en = 1'b1;
    rst_n  = 1'b1;
    repeat (6) step();
    log_en = 1'b0;
    n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL fill_issue_cnt: got %0d want 4", issued.size()); end
    for (int i = 0; i < 4 && i < issued.size(); i++) begin
      n_cmp++; if (issued[i] !== AW'(i)) begin n_bad++; $display("FAIL fill_addr[%0d]: got %h want %h", i, issued[i], AW'(i)); end
    end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count); end
    n_cmp++; if (ram_rd_en1 !== 1'b0) begin n_bad++; $display("FAIL fill_rd_en: got %b want 0", ram_rd_en1); end
    n_cmp++; if (instr !== 32'hE000_0000) begin n_bad++; $display("FAIL fill_instr: got %h want e0000000", instr); end
    n_cmp++; if (instr_pc !== 11'h000 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL fill_head: got pc %h v %b want pc 000 v 1", instr_pc, instr_valid); end
  endtask

  task automatic test_throughput;
    deq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'hE000_0000 + i || count > 3'd4) begin
        n_bad++;
        $display("FAIL stream[%0d]: got v %b instr %h cnt %0d want v 1 instr %h cnt<=4", i, instr_valid, instr, count, 32'hE000_0000 + i);
      end
      step();
    end
    deq = 1'b0;
  endtask

  task automatic test_redirect;
    redirect = 1'b1; redirect_pc = 11'h000;
    step();
    redirect = 1'b0;
    repeat (4) step();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL redir_pre_count: got %0d want 3", count); end
    redirect = 1'b1; redirect_pc = 11'h100;
    #1;
    n_cmp++; if (ram_rd_en1 !== 1'b0) begin n_bad++; $display("FAIL redir_rd_en: got %b want 0", ram_rd_en1); end
    step();
    redirect = 1'b0;
    n_cmp++; if (count !== 3'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got cnt %0d v %b want cnt 0 v 0", count, instr_valid); end
    step();
`ifdef IFQ_BYPASS_EN
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 11'h100) begin n_bad++; $display("FAIL redir_lat1: got v %b pc %h want v 1 pc 100", instr_valid, instr_pc); end
`else
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_lat1: got v %b want 0", instr_valid); end
`endif
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0100 || instr_pc !== 11'h100) begin
      n_bad++; $display("FAIL redir_first: got v %b instr %h pc %h want v 1 instr e0000100 pc 100", instr_valid, instr, instr_pc);
    end
    deq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 11'h100 + AW'(i)) begin
        n_bad++; $display("FAIL redir_seq[%0d]: got v %b pc %h want v 1 pc %h", i, instr_valid, instr_pc, 11'h100 + AW'(i));
      end
      step();
    end
    deq = 1'b0;
  endtask

  task automatic test_redirect_deq;
    redirect = 1'b1; redirect_pc = 11'h200;
    step();
    redirect = 1'b0;
    repeat (3) step();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rdq_pre_count: got %0d want 2", count); end
    redirect = 1'b1; redirect_pc = 11'h300; deq = 1'b1;
    step();
    redirect = 1'b0;
    n_cmp++; if (count !== 3'd0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rdq_flush: got cnt %0d v %b want cnt 0 v 0", count, instr_valid); end
    step();
    deq = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL empty_deq_count: got %0d want 0", count); end
    step();
    n_cmp++; if (count !== 3'd1 || instr_valid !== 1'b1 || instr !== 32'hE000_0300 || instr_pc !== 11'h300) begin
      n_bad++; $display("FAIL rdq_first: got cnt %0d v %b instr %h pc %h want cnt 1 v 1 instr e0000300 pc 300", count, instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_w [4];
    exp_w = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    redirect = 1'b1; redirect_pc = 11'h7FE;
    step();
    redirect = 1'b0;
    issued.delete();
    log_en = 1'b1;
    repeat (6) step();
    log_en = 1'b0;
    n_cmp++; if (issued.size() != 4) begin n_bad++; $display("FAIL wrap_issue_cnt: got %0d want 4", issued.size()); end
    for (int i = 0; i < 4 && i < issued.size(); i++) begin
      n_cmp++; if (issued[i] !== exp_w[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, issued[i], exp_w[i]); end
    end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", count); end
    deq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_pc !== exp_w[i] || instr !== 32'hE000_0000 + {21'b0, exp_w[i]}) begin
        n_bad++; $display("FAIL wrap_head[%0d]: got pc %h instr %h want pc %h", i, instr_pc, instr, exp_w[i]);
      end
      step();
    end
    deq = 1'b0;
  endtask

  task automatic test_async_reset;
    deq = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ram_rd_en1 !== 1'b0 || ram_addr1 !== 11'h000) begin n_bad++; $display("FAIL arst_ram: got en %b addr %h want en 0 addr 000", ram_rd_en1, ram_addr1); end
    n_cmp++; if (instr !== 32'h0 || instr_pc !== 11'h000 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL arst_head: got instr %h pc %h v %b want 0 000 0", instr, instr_pc, instr_valid);
    end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", count); end
    #1;
    deq = 1'b0;
    rst_n = 1'b1;
    issued.delete();
    log_en = 1'b1;
    @(negedge clk);
    step();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL arst_stale_drop: got cnt %0d want 0", count); end
    step();
    log_en = 1'b0;
    n_cmp++; if (issued.size() < 1 || issued[0] !== 11'h000) begin n_bad++; $display("FAIL arst_first_addr: got n %0d want first addr 000", issued.size()); end
    n_cmp++; if (count !== 3'd1 || instr !== 32'hE000_0000 || instr_pc !== 11'h000 || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL arst_first_word: got cnt %0d instr %h pc %h v %b want 1 e0000000 000 1", count, instr, instr_pc, instr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_throughput();
    test_redirect();
    test_redirect_deq();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
